// File: rtl/and_run_mon_pkg.sv
// Shared definitions for the AND-result run monitor: FSM state encoding,
// the saturation limit for a counter width, and the pointer-width helper.
package and_run_mon_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  function automatic int unsigned sat_max(input int unsigned w);
    return (32'd1 << w) - 32'd1;
  endfunction

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 1; i < v; i = i << 1) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/and_run_mon_fifo.sv
// Synchronous CNT_W x DEPTH FIFO for completed run lengths. A push at full
// is still accepted when a pop happens in the same cycle.
module and_run_mon_fifo
  import and_run_mon_pkg::*;
#(
  parameter int unsigned CNT_W = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [CNT_W-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] head
);

  localparam int unsigned PW = clog2(DEPTH);

  logic [CNT_W-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_q;
  logic [PW-1:0]    rd_q;
  logic [PW:0]      cnt_q;
  logic             do_pop;
  logic             do_push;

  assign full    = (cnt_q == (PW + 1)'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign head    = empty ? '0 : mem_q[rd_q];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= push_data;
        wr_q        <= wr_q + PW'(1);
      end
      if (do_pop) rd_q <= rd_q + PW'(1);
      cnt_q <= cnt_q + (PW + 1)'(do_push) - (PW + 1)'(do_pop);
    end
  end

endmodule

// File: rtl/and_run_monitor.sv
// Samples the 3-input AND result, counts rising events and queues completed
// high-run lengths. Define AND_RUN_MONITOR_XCHK_EN to enable sticky X/Z detect.
module and_run_monitor
  import and_run_mon_pkg::*;
#(
  parameter int unsigned CNT_W = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sample_en,
  input  logic             din,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [CNT_W-1:0] evt_len,
  output logic [CNT_W-1:0] rise_cnt,
  output logic             overflow,
  output logic             busy,
  output logic             x_seen
);

  localparam logic [CNT_W-1:0] MAX = CNT_W'(sat_max(CNT_W));

  state_e           state_q;
  logic [CNT_W-1:0] run_len_q;
  logic [CNT_W-1:0] rise_q;
  logic             ovf_q;
  logic             ovf_d;
  logic             din_one;
  logic             push;
  logic             full;
  logic             empty;

`ifdef AND_RUN_MONITOR_XCHK_EN
  logic xs_q;
  logic din_bad;

  // Unknown samples count as 0 so they terminate a run like a real low.
  assign din_bad = (din !== 1'b0) && (din !== 1'b1);
  assign din_one = (din === 1'b1);
  assign x_seen  = xs_q;

  always_ff @(posedge clk) begin
    if (rst)                        xs_q <= 1'b0;
    else if (sample_en && din_bad)  xs_q <= 1'b1;
  end
`else
  always_comb begin
    din_one = 1'b0;
    if (din) din_one = 1'b1;
  end
  assign x_seen = 1'b0;
`endif

  assign push      = sample_en & (state_q == RUN) & ~din_one;
  assign ovf_d     = push & full & ~(evt_ready & ~empty);
  assign evt_valid = ~empty;
  assign busy      = (state_q == RUN);
  assign rise_cnt  = rise_q;
  assign overflow  = ovf_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      run_len_q <= '0;
      rise_q    <= '0;
      ovf_q     <= 1'b0;
    end else begin
      if (ovf_d) ovf_q <= 1'b1;
      if (sample_en) begin
        case (state_q)
          IDLE: begin
            if (din_one) begin
              state_q   <= RUN;
              run_len_q <= CNT_W'(1);
              if (rise_q != MAX) rise_q <= rise_q + CNT_W'(1);
            end
          end
          RUN: begin
            if (din_one) begin
              if (run_len_q != MAX) run_len_q <= run_len_q + CNT_W'(1);
            end else begin
              state_q   <= IDLE;
              run_len_q <= '0;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  and_run_mon_fifo #(
    .CNT_W(CNT_W),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_data(run_len_q),
    .pop      (evt_ready),
    .full     (full),
    .empty    (empty),
    .head     (evt_len)
  );

endmodule
